// File: rtl/flag_pkg.sv
// rtl/flag_pkg.sv - shared types for the flag/condition unit
// Condition codes, ALU op codes, FSM states and NZCV bit positions.
package flag_pkg;

  typedef enum logic [3:0] {
    COND_EQ, COND_NE, COND_CS, COND_CC, COND_MI, COND_PL, COND_VS, COND_VC,
    COND_HI, COND_LS, COND_GE, COND_LT, COND_GT, COND_LE, COND_AL, COND_NV
  } cond_e;

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_AND = 4'd2;
  localparam logic [3:0] OP_OR  = 4'd3;
  localparam logic [3:0] OP_XOR = 4'd4;
  localparam logic [3:0] OP_NOT = 4'd5;
  localparam logic [3:0] OP_SLL = 4'd6;
  localparam logic [3:0] OP_SRL = 4'd7;
  localparam logic [3:0] OP_SRA = 4'd8;
  localparam logic [3:0] OP_ROL = 4'd9;
  localparam logic [3:0] OP_ROR = 4'd10;
  localparam logic [3:0] OP_MUL = 4'd11;

  typedef enum logic [1:0] {IDLE, EVAL, RESP} state_e;

  localparam int N_BIT = 3;
  localparam int Z_BIT = 2;
  localparam int C_BIT = 1;
  localparam int V_BIT = 0;

endpackage

// File: rtl/cond_decode.sv
// rtl/cond_decode.sv - combinational condition-code evaluation
// Maps a condition code and an NZCV value to the taken bit.
module cond_decode
  import flag_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [3:0] nzcv,
  output logic       taken
);

  logic n, z, c, v;

  always_comb begin
    n = nzcv[N_BIT];
    z = nzcv[Z_BIT];
    c = nzcv[C_BIT];
    v = nzcv[V_BIT];
    taken = 1'b0;
    case (cond_e'(cond))
      COND_EQ: taken = z;
      COND_NE: taken = !z;
      COND_CS: taken = c;
      COND_CC: taken = !c;
      COND_MI: taken = n;
      COND_PL: taken = !n;
      COND_VS: taken = v;
      COND_VC: taken = !v;
      COND_HI: taken = c && !z;
      COND_LS: taken = !c || z;
      COND_GE: taken = (n == v);
      COND_LT: taken = (n != v);
      COND_GT: taken = !z && (n == v);
      COND_LE: taken = z || (n != v);
      COND_AL: taken = 1'b1;
      default: taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/flag_cond_unit.sv
// rtl/flag_cond_unit.sv - NZCV status register with condition query handshake
// Optional sticky C/V tracking is enabled by defining FLAG_STICKY_EN.
module flag_cond_unit
  import flag_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flag_we,
  input  logic [3:0]       flag_op,
  input  logic             in_c,
  input  logic             in_n,
  input  logic             in_v,
  input  logic             in_z,
  input  logic             cond_valid,
  output logic             cond_ready,
  input  logic [3:0]       cond,
  output logic             res_valid,
  input  logic             res_ready,
  output logic             res_taken,
  output logic [3:0]       nzcv,
  output logic [CNT_W-1:0] ovf_cnt,
  output logic             illegal_op
`ifdef FLAG_STICKY_EN
  ,
  input  logic             clr_sticky,
  output logic [1:0]       sticky_cv
`endif
);

  logic wr_full, wr_mul, wr_logic, wr_bad, wr_cv;
  state_e state, next_state;
  logic [3:0] cond_q;
  logic eval_taken;

  assign wr_full  = flag_we && (flag_op == OP_ADD || flag_op == OP_SUB);
  assign wr_mul   = flag_we && (flag_op == OP_MUL);
  assign wr_logic = flag_we && (flag_op >= OP_AND) && (flag_op <= OP_ROR);
  assign wr_bad   = flag_we && (flag_op > OP_MUL);
  assign wr_cv    = wr_full || wr_mul;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      nzcv       <= 4'b0000;
      illegal_op <= 1'b0;
      ovf_cnt    <= '0;
    end else begin
      illegal_op <= wr_bad;
      if (wr_full)
        nzcv <= {in_n, in_z, in_c, in_v};
      else if (wr_mul)
        nzcv <= {1'b0, in_z, in_c, in_v};
      else if (wr_logic)
        nzcv[Z_BIT] <= in_z;
      // saturate rather than wrap so software can detect "many" events
      if (wr_cv && in_v && (ovf_cnt != {CNT_W{1'b1}}))
        ovf_cnt <= ovf_cnt + CNT_W'(1);
    end
  end

`ifdef FLAG_STICKY_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      sticky_cv <= 2'b00;
    else if (clr_sticky)
      sticky_cv <= 2'b00;
    else if (wr_cv)
      sticky_cv <= sticky_cv | {in_c, in_v};
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cond_q    <= 4'd0;
      res_taken <= 1'b0;
    end else begin
      state <= next_state;
      if (state == IDLE && cond_valid)
        cond_q <= cond;
      // nzcv here already holds writes strobed up to the handshake cycle
      if (state == EVAL)
        res_taken <= eval_taken;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (cond_valid) next_state = EVAL;
      EVAL:    next_state = RESP;
      RESP:    if (res_ready) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    cond_ready = (state == IDLE);
    res_valid  = (state == RESP);
  end

  cond_decode u_cond_decode (
    .cond  (cond_q),
    .nzcv  (nzcv),
    .taken (eval_taken)
  );

endmodule
